mult_seq: RTL and testbench

- Parametrised sequential shift-add multiplier for WIDTH-bit operands, producing a full 2*WIDTH-bit product.
- Successor to the team's fixed 2-bit combinational multiplier: arbitrary width, valid/ready handshakes on both sides, fixed multi-cycle latency.
- Used wherever area matters more than throughput. Optional signed mode.

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_seq_dp.sv | 103 ++++++++++
 rtl/mult_seq.sv | 96 +++++++++
 tb/tb_mult_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the mult_seq shift-add multiplier.
// Optional signed mode is selected by the MULT_SIGNED_EN macro.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter must be able to hold WIDTH itself after the final increment.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mult_seq_dp.sv
// Datapath of mult_seq: operand registers, accumulator, shift/add step and result register.
// With MULT_SIGNED_EN defined, operands are two's complement and the product sign is fixed up at the end.
module mult_seq_dp
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = cnt_w(WIDTH);
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [PW-1:0]    acc_r;
    logic [PW-1:0]    result_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [PW-1:0]    addend_s;
    logic [PW-1:0]    sum_s;
    logic [PW-1:0]    final_s;
`ifdef MULT_SIGNED_EN
    logic             sign_r;

    // The most-negative value maps to its unsigned magnitude 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction
`endif

    assign last   = (count_r == LAST_CNT);
    assign result = result_r;

    // Operand magnitudes, partial product for this step and final product.
    always_comb begin
`ifdef MULT_SIGNED_EN
        a_mag_s = mag(a);
        b_mag_s = mag(b);
`else
        a_mag_s = a;
        b_mag_s = b;
`endif
        if (mplier_r[0]) begin
            addend_s = {{WIDTH{1'b0}}, mcand_r} << count_r;
        end else begin
            addend_s = {PW{1'b0}};
        end
        sum_s = acc_r + addend_s;
`ifdef MULT_SIGNED_EN
        if (sign_r) begin
            final_s = ~sum_s + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            final_s = sum_s;
        end
`else
        final_s = sum_s;
`endif
    end

    // Operand capture on accept, one shift-add per CALC cycle, result on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {PW{1'b0}};
            result_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
`ifdef MULT_SIGNED_EN
            sign_r   <= 1'b0;
`endif
        end else if (load) begin
            mcand_r  <= a_mag_s;
            mplier_r <= b_mag_s;
            acc_r    <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
`ifdef MULT_SIGNED_EN
            sign_r   <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
        end else if (step) begin
            acc_r    <= sum_s;
            mplier_r <= mplier_r >> 1;
            count_r  <= count_r + {{(CW-1){1'b0}}, 1'b1};
            if (last) begin
                result_r <= final_s;
            end
        end
    end

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier top: FSM and valid/ready handshakes around mult_seq_dp.
// Define MULT_SIGNED_EN for two's complement operands.
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    state_t state_r;
    state_t state_next_s;
    logic   in_ready_r;
    logic   out_valid_r;
    logic   busy_r;
    logic   load_s;
    logic   step_s;
    logic   last_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

    // State register; handshake flags are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
            busy_r      <= (state_next_s != IDLE);
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    load_s       = 1'b1;
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            DONE: begin
                if (out_valid_r && out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    mult_seq_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_s),
        .step   (step_s),
        .a      (a),
        .b      (b),
        .last   (last_s),
        .result (result)
    );

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: vector table, scoreboard queue and handshake corner cases.
module tb_mult_seq;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] result;
    logic          busy;

    int total;
    int bad;
    int rx_cnt;
    logic [PW-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [PW-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    mult_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MULT_SIGNED_EN
        return PW'(int'($signed(x)) * int'($signed(y)));
`else
        return PW'(x) * PW'(y);
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: the handshake completes at the next edge, so the negedge sees it.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            rx_cnt++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: act=%0h exp=none", result);
            end else begin
                logic [PW-1:0] e;
                e = exp_q.pop_front();
                if (result !== e) begin
                    bad++;
                    $display("FAIL result: act=%0h exp=%0h", result, e);
                end
            end
        end
    end

    // Present operands until accepted, then measure accept-to-out_valid latency.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [PW-1:0] ev);
        int n;
        a = av;
        b = bv;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_timeout", 32'(n < 50), 32'd1);
        exp_q.push_back(ev);
        tick();
        in_valid = 1'b0;
        a = ~av;
        b = ~bv;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(W));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rx_cnt    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 8'd0;
        b         = 8'd0;

`ifdef MULT_SIGNED_EN
        vecs[0] = '{8'hFD, 8'h05, 16'hFFF1};
        vecs[1] = '{8'h80, 8'h80, 16'h4000};
        vecs[2] = '{8'h7F, 8'hFF, 16'hFF81};
        vecs[3] = '{8'h0D, 8'h0B, 16'h008F};
`else
        vecs[0] = '{8'd13, 8'd11, 16'h008F};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01};
        vecs[2] = '{8'd0, 8'd200, 16'h0000};
        vecs[3] = '{8'd1, 8'd1, 16'h0001};
`endif
        for (int i = 4; i < 8; i++) begin
            vecs[i].a   = 8'($urandom_range(0, 255));
            vecs[i].b   = 8'($urandom_range(0, 255));
            vecs[i].exp = ref_mul(vecs[i].a, vecs[i].b);
        end

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp);
            chk("busy_done", 32'(busy), 32'd1);
            tick();
            chk("valid_pulse", 32'(out_valid), 32'd0);
            chk("result_hold", 32'(result), 32'(vecs[i].exp));
        end

        // Backpressure: DONE holds while new operands are ignored.
        out_ready = 1'b0;
        run_op(8'd6, 8'd7, 16'd42);
        in_valid = 1'b1;
        a = 8'd9;
        b = 8'd9;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_result", 32'(result), 32'd42);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 12; i++) tick();
        chk("bp_no_extra", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of CALC at count 4.
        a = 8'd200;
        b = 8'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        run_op(8'd7, 8'd9, 16'd63);
        tick();

        // Back-to-back with in_valid held high.
        rx_cnt = 0;
        begin
            logic [W-1:0] oa[3];
            logic [W-1:0] ob[3];
            int idx;
            int guard;
            oa[0] = 8'd3;   ob[0] = 8'd5;
            oa[1] = 8'd100; ob[1] = 8'd2;
            oa[2] = 8'd17;  ob[2] = 8'd17;
            idx = 0;
            guard = 0;
            in_valid = 1'b1;
            while (idx < 3 && guard < 100) begin
                a = oa[idx];
                b = ob[idx];
                if (in_ready) begin
                    exp_q.push_back(ref_mul(oa[idx], ob[idx]));
                    idx++;
                end
                tick();
                guard++;
            end
            in_valid = 1'b0;
            chk("b2b_accepts", 32'(idx), 32'd3);
            guard = 0;
            while (exp_q.size() != 0 && guard < 100) begin
                tick();
                guard++;
            end
            tick();
            chk("b2b_drained", 32'(exp_q.size()), 32'd0);
            chk("b2b_count", 32'(rx_cnt), 32'd3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
